// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter unit and the CPU control unit.
//   The control unit drives pc_unit.mode with these same constants, so the
//   encodings here are part of the datapath/control contract and must not move.
// -----------------------------------------------------------------------------
package pc_pkg;

    // Next-PC selection codes driven by the control unit.
    typedef logic [1:0] pc_mode_t;

    localparam pc_mode_t MODE_SEQ    = 2'b00;  // pc + STEP
    localparam pc_mode_t MODE_BRANCH = 2'b01;  // conditional pc-relative
    localparam pc_mode_t MODE_JUMP   = 2'b10;  // absolute target (optionally a call)
    localparam pc_mode_t MODE_RET    = 2'b11;  // pop return-address stack

    // Mask that keeps every bit of a WIDTH-bit address except the low
    // 'align' bits. Written as a function so both the RTL and any later
    // user of the package build the mask the same way.
    function automatic logic [63:0] align_mask64(input int align);
        logic [63:0] low_bits;
        low_bits = (64'd1 << align) - 64'd1;
        return ~low_bits;
    endfunction

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
//   Circular return-address stack.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset (ptr and count only)
//     push       in   write din at ptr, advance ptr
//     pop        in   retreat ptr (ignored while empty)
//     din        in   WIDTH   return address to push
//     top        out  WIDTH   entry at ptr-1 (most recent push)
//     count      out  valid entries, 0..RAS_DEPTH
//     empty      out  count == 0
//     full       out  count == RAS_DEPTH
//     ovf_pulse  out  push seen while full (oldest entry overwritten)
//     udf_pulse  out  pop seen while empty
//
//   The stack never refuses a push: when full, the write simply lands on the
//   oldest slot because ptr wraps modulo RAS_DEPTH, and count saturates.
//   push and pop are mutually exclusive by construction in the caller; push
//   wins if both are ever asserted.
// -----------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]  count,
    output logic                        empty,
    output logic                        full,
    output logic                        ovf_pulse,
    output logic                        udf_pulse
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;
    logic             wr_en;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_MAX);
    assign count     = count_q;
    assign ovf_pulse = push && full;
    assign udf_pulse = pop && !push && empty;

    // ptr points at the next free slot; the newest entry sits one below it.
    // RAS_DEPTH is a power of two, so the subtraction wraps to the last slot.
    assign top_idx = ptr_q - PTR_ONE;
    assign top     = mem_q[top_idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_ONE;
            if (!full) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry storage has no reset; count==0 already marks every entry
    // invalid, and leaving the array reset-free lets it map onto plain RAM/regs.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule : pc_ras

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program-counter register plus next-PC selection for the CPU datapath.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset, overrides ena
//     ena        in   advance enable; 0 freezes pc, RAS and flags
//     mode       in   2      next-PC mode (pc_pkg MODE_*)
//     br_taken   in   branch condition, BRANCH mode only
//     offset     in   WIDTH  signed byte offset for BRANCH
//     target     in   WIDTH  absolute target for JUMP
//     call       in   JUMP is a call: push pc+STEP
//     pc         out  WIDTH  current PC (registered)
//     ras_count  out  valid RAS entries
//     ras_empty  out  RAS has no entries
//     ras_full   out  RAS holds RAS_DEPTH entries
//     err_ovf    out  sticky: push while RAS full
//     err_udf    out  sticky: RET while RAS empty
//     err_mis    out  sticky: redirect target had nonzero low ALIGN bits
//
//   The next PC is always written aligned. Only redirects (taken branch,
//   jump, non-empty return) are checked for misalignment; sequential
//   fetch and the empty-RET fallback are pc+STEP from an aligned pc.
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0040_0000,
    parameter int               STEP      = 4,
    parameter int               ALIGN     = 2,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  pc_mode_t                    mode,
    input  logic                        br_taken,
    input  logic [WIDTH-1:0]            offset,
    input  logic [WIDTH-1:0]            target,
    input  logic                        call,
    output logic [WIDTH-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        err_ovf,
    output logic                        err_udf,
    output logic                        err_mis
);

    localparam logic [63:0]      MASK64     = align_mask64(ALIGN);
    localparam logic [WIDTH-1:0] ALIGN_MASK = MASK64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_udf_q, err_udf_d;
    logic             err_mis_q, err_mis_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] nxt_raw;
    logic             redirect;
    logic             mis_now;

    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_ovf_pulse;
    logic             ras_udf_pulse;

    // call only matters on an enabled JUMP; in any other mode it is ignored.
    assign ras_push = ena && (mode == MODE_JUMP) && call;
    assign ras_pop  = ena && (mode == MODE_RET);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .din       (seq_pc),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_pulse (ras_ovf_pulse),
        .udf_pulse (ras_udf_pulse)
    );

    // Next-PC mux. All arithmetic is modulo 2^WIDTH; offset is already a
    // two's-complement WIDTH-bit value, so a plain add sign-extends for free.
    always_comb begin
        seq_pc   = pc_q + STEP_W;
        nxt_raw  = seq_pc;
        redirect = 1'b0;
        case (mode)
            MODE_SEQ: begin
                nxt_raw = seq_pc;
            end
            MODE_BRANCH: begin
                if (br_taken) begin
                    nxt_raw  = pc_q + offset;
                    redirect = 1'b1;
                end
            end
            MODE_JUMP: begin
                nxt_raw  = target;
                redirect = 1'b1;
            end
            MODE_RET: begin
                // Empty RET falls through to pc+STEP and is flagged below.
                if (!ras_empty) begin
                    nxt_raw  = ras_top;
                    redirect = 1'b1;
                end
            end
            default: begin
                nxt_raw = seq_pc;
            end
        endcase

        mis_now = redirect && ((nxt_raw & ~ALIGN_MASK) != '0);

        pc_d      = ena ? (nxt_raw & ALIGN_MASK) : pc_q;
        err_mis_d = err_mis_q | (ena & mis_now);
        // RAS pulses are already qualified by ena through push/pop.
        err_ovf_d = err_ovf_q | ras_ovf_pulse;
        err_udf_d = err_udf_q | ras_udf_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VEC;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
            err_mis_q <= err_mis_d;
        end
    end

    assign pc      = pc_q;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
    assign err_mis = err_mis_q;

endmodule : pc_unit
